// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : UART transmitter with a word FIFO in front of it. Frames are
//             start bit, DATA_WIDTH data bits LSB first, optional parity and
//             STOP_BITS stop bits. Queued words go out back-to-back with no
//             idle gap. A break request holds the line low and is honoured
//             only between frames.
//  Ports    : clk        - sole clock, rising edge
//             rst        - synchronous active-high reset
//             i_vld      - write request (accepted when o_rdy is high)
//             i_data     - word to transmit
//             o_rdy      - FIFO can accept a word
//             i_baud_div - clocks per bit, 0 = CLK_FREQ/BAUD_RATE, 1..15 -> 16
//             i_break    - request to hold the line low
//             o_busy     - frame or break in progress
//             o_fifo_cnt - words queued
//             tx         - registered serial line, idle high
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int    DATA_WIDTH   = 8,
   parameter string PARITY_CHECK = "NONE",
   parameter int    STOP_BITS    = 1,
   parameter int    FIFO_DEPTH   = 16,
   parameter int    CLK_FREQ     = 50000000,
   parameter int    BAUD_RATE    = 9600
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_vld,
   input  logic [DATA_WIDTH-1:0]         i_data,
   output logic                          o_rdy,
   input  logic [15:0]                   i_baud_div,
   input  logic                          i_break,
   output logic                          o_busy,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
   output logic                          tx
);

   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int DEF_DIV  = (BAUD_RATE > 0) ? (CLK_FREQ / BAUD_RATE) : 0;
   // 0 NONE, 1 ODD, 2 EVEN, 3 MARK, 4 SPACE, 7 illegal
   localparam int PAR_MODE = (PARITY_CHECK == "NONE")  ? 0 :
                             (PARITY_CHECK == "ODD")   ? 1 :
                             (PARITY_CHECK == "EVEN")  ? 2 :
                             (PARITY_CHECK == "MARK")  ? 3 :
                             (PARITY_CHECK == "SPACE") ? 4 : 7;
   localparam bit PAR_EN   = (PAR_MODE != 0);
   localparam bit PARAM_OK = (DATA_WIDTH >= 5) && (DATA_WIDTH <= 9) &&
                             (PAR_MODE != 7) &&
                             ((STOP_BITS == 1) || (STOP_BITS == 2)) &&
                             (FIFO_DEPTH >= 2) &&
                             ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) &&
                             (BAUD_RATE > 0) && (DEF_DIV >= 16) && (DEF_DIV <= 65535);

   localparam logic [15:0] DEF_DIV16 = 16'(DEF_DIV);
   localparam logic [AW:0] CNT_FULL  = (AW+1)'(FIFO_DEPTH);

   generate
      if (!PARAM_OK) begin : g_param_check
         $error("uart_tx_fifo: illegal parameter value or CLK_FREQ/BAUD_RATE < 16");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

   // ---------------------------------------------------------------- FIFO
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           cnt;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] head;

   assign o_rdy      = (cnt != CNT_FULL);
   assign o_fifo_cnt = cnt;
   assign push       = i_vld && o_rdy;
   assign head       = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst && push)
         mem[wr_ptr] <= i_data;
   end

   // Power-of-two depth: pointers wrap naturally at AW bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            cnt <= cnt + 1'b1;
         else if (pop && !push)
            cnt <= cnt - 1'b1;
      end
   end

   // ---------------------------------------------------------------- TX FSM
   state_t                state;
   logic [15:0]           div_q;
   logic [15:0]           baud_cnt;
   logic [DATA_WIDTH-1:0] shreg;
   logic                  par_bit;
   logic [3:0]            bit_idx;
   logic                  stop_idx;
   logic                  releasing;   // break released, sending the trailing high time
   logic [15:0]           eff_div;
   logic                  bit_end;
   logic                  at_bound;

   assign eff_div = (i_baud_div == 16'd0)  ? DEF_DIV16 :
                    (i_baud_div <  16'd16) ? 16'd16    : i_baud_div;
   assign bit_end = (baud_cnt == div_q - 16'd1);

   // Frame boundary: idle, last clock of the final stop bit, or last clock of
   // the post-break high time. Only here may a new frame or a break begin.
   assign at_bound = (state == IDLE) ||
                     ((state == STOP) && bit_end && (stop_idx == 1'(STOP_BITS - 1))) ||
                     ((state == BREAK) && releasing && bit_end);
   assign pop      = at_bound && (cnt != '0) && !i_break;
   assign o_busy   = (state != IDLE);

   function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d);
      logic p;
      case (PAR_MODE)
         1:       p = ~^d;
         2:       p = ^d;
         3:       p = 1'b1;
         default: p = 1'b0;
      endcase
      return p;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tx        <= 1'b1;
         div_q     <= 16'd16;
         baud_cnt  <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         releasing <= 1'b0;
      end else if (at_bound) begin
         baud_cnt  <= '0;
         releasing <= 1'b0;
         if (pop) begin
            // Divisor and word are latched here so later i_baud_div changes
            // cannot disturb the frame in flight.
            state   <= START;
            tx      <= 1'b0;
            div_q   <= eff_div;
            shreg   <= head;
            par_bit <= parity_of(head);
         end else if (i_break) begin
            state <= BREAK;
            tx    <= 1'b0;
            div_q <= eff_div;
         end else begin
            state <= IDLE;
            tx    <= 1'b1;
         end
      end else begin
         baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
         case (state)
            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_idx <= '0;
               end
            end
            DATA: begin
               if (bit_end) begin
                  if (bit_idx == 4'(DATA_WIDTH - 1)) begin
                     if (PAR_EN) begin
                        state <= PARITY;
                        tx    <= par_bit;
                     end else begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        stop_idx <= 1'b0;
                     end
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_idx <= bit_idx + 4'd1;
                  end
               end
            end
            PARITY: begin
               if (bit_end) begin
                  state    <= STOP;
                  tx       <= 1'b1;
                  stop_idx <= 1'b0;
               end
            end
            STOP: begin
               // Final stop bit end is handled as a boundary above.
               if (bit_end)
                  stop_idx <= 1'b1;
            end
            BREAK: begin
               if (!releasing) begin
                  baud_cnt <= '0;
                  if (!i_break) begin
                     releasing <= 1'b1;
                     tx        <= 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
